// File: rtl/dvp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dvp_pkg
// Description : Shared definitions for the DVP sensor emulator: FSM state
//               encoding, sync polarities, RGB565 colour-bar constants and
//               small elaboration-time helpers.
// Macro       : DVP_TX_COLORBAR_EN (the colour constants are only consumed
//               when this macro is defined)
// Revision    : 1.0 - initial release
// ============================================================================
package dvp_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } dvp_state_t;

    // Sync polarities; the inactive level is the complement
    localparam logic C_VSYNC_ACTIVE = 1'b1;
    localparam logic C_HREF_ACTIVE  = 1'b1;

    // RGB565 bar colours, left to right
    localparam logic [15:0] C_RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] C_RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] C_RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_RGB_RED     = 16'hF800;
    localparam logic [15:0] C_RGB_BLUE    = 16'h001F;
    localparam logic [15:0] C_RGB_BLACK   = 16'h0000;

    // Colour of bar number idx (0 = leftmost)
    function automatic logic [15:0] f_bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_RGB_WHITE;
            3'd1:    return C_RGB_YELLOW;
            3'd2:    return C_RGB_CYAN;
            3'd3:    return C_RGB_GREEN;
            3'd4:    return C_RGB_MAGENTA;
            3'd5:    return C_RGB_RED;
            3'd6:    return C_RGB_BLUE;
            default: return C_RGB_BLACK;
        endcase
    endfunction

    // Bits needed for a counter that runs 0..count-1 (never less than 1)
    function automatic int f_cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    function automatic int f_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_tx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : dvp_tx_pattern_gen
// Description : Combinational test-pattern source. Returns the byte to put
//               on the DVP bus for the current horizontal byte position and
//               active line; 0 whenever href is low.
//               DVP_TX_COLORBAR_EN defined   : 8 vertical RGB565 bars,
//                                              high byte first.
//               DVP_TX_COLORBAR_EN undefined : (h_cnt + line) mod 256.
// Ports       : i_h_cnt    - byte position within the line
//               i_line_idx - line index within the active region
//               i_href     - this byte lies inside the active window
//               o_byte     - pixel byte
// Revision    : 1.0 - initial release
// ============================================================================
module dvp_tx_pattern_gen
    import dvp_pkg::*;
#(
`ifdef DVP_TX_COLORBAR_EN
    parameter int H_ACTIVE = 640,
`endif
    parameter int H_W      = 11,
    parameter int V_W      = 9
) (
    input  logic [H_W-1:0] i_h_cnt,
    input  logic [V_W-1:0] i_line_idx,
    input  logic           i_href,
    output logic [7:0]     o_byte
);

`ifdef DVP_TX_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 8;

    int unsigned w_bar;
    logic [2:0]  w_bar_idx;
    logic [15:0] w_colour;

    always_comb begin
        // Two bytes per pixel, so the pixel index is h_cnt/2
        w_bar     = 32'(i_h_cnt >> 1) / BAR_W;
        // Leftover pixels when H_ACTIVE is not a multiple of 8 stay in the last bar
        w_bar_idx = (w_bar > 32'd7) ? 3'd7 : w_bar[2:0];
        w_colour  = f_bar_colour(w_bar_idx);
        o_byte    = 8'h00;
        if (i_href) begin
            o_byte = i_h_cnt[0] ? w_colour[7:0] : w_colour[15:8];
        end
    end
`else
    // Wide enough that the sum never wraps before the final mod-256 truncation
    localparam int S_W = (H_W > 8) ? H_W : 8;

    always_comb begin
        o_byte = 8'h00;
        if (i_href) begin
            o_byte = 8'(S_W'(i_h_cnt) + S_W'(i_line_idx));
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/dvp_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module      : dvp_sensor_emulator
// Description : DVP camera-side transmitter standing in for an image sensor.
//               Generates PCLK (= clk/2), VSYNC, HREF and 8-bit RGB565 data
//               for a parameterised frame geometry. Data changes on the clk
//               edge where PCLK falls (a "tick") and is stable at PCLK rise.
// Macro       : DVP_TX_COLORBAR_EN - colour bars instead of counting pattern
// Ports       : clk          - sensor master clock
//               rst_n        - asynchronous active-low reset
//               pwdn_i       - power-down, asynchronous, active high
//               dvp_pclk_o   - pixel clock
//               dvp_vsync_o  - frame sync, active high
//               dvp_href_o   - line valid, active high
//               dvp_d_o      - pixel byte
//               frame_done_o - one-clk pulse at end of each complete frame
// Revision    : 1.0 - initial release
// ============================================================================
module dvp_sensor_emulator
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwdn_i,
    output logic       dvp_pclk_o,
    output logic       dvp_vsync_o,
    output logic       dvp_href_o,
    output logic [7:0] dvp_d_o,
    output logic       frame_done_o
);

    localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
    localparam int H_W        = f_cnt_width(LINE_TICKS);
    localparam int MAX_LINES  = f_max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);
    localparam int V_W        = f_cnt_width(MAX_LINES);

    localparam logic [H_W-1:0] C_H_LAST       = H_W'(LINE_TICKS - 1);
    localparam logic [H_W-1:0] C_HREF_END     = H_W'(2 * H_ACTIVE);
    // Last-line values of zero-length states wrap, but those states are never entered
    localparam logic [V_W-1:0] C_VSYNC_LAST   = V_W'(VSYNC_LINES - 1);
    localparam logic [V_W-1:0] C_VBACK_LAST   = V_W'(V_BACK - 1);
    localparam logic [V_W-1:0] C_ACTIVE_LAST  = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] C_VFRONT_LAST  = V_W'(V_FRONT - 1);

    // ------------------------------------------------------------------
    // Power-down synchroniser; resets to "powered down" so the sequencer
    // starts cleanly a couple of clocks after reset release.
    // ------------------------------------------------------------------
    logic r_pwdn_meta;
    logic r_pwdn_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwdn_meta <= 1'b1;
            r_pwdn_s    <= 1'b1;
        end else begin
            r_pwdn_meta <= pwdn_i;
            r_pwdn_s    <= r_pwdn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state and output registers
    // ------------------------------------------------------------------
    dvp_state_t     r_state;
    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic           r_pclk;
    logic           r_vsync;
    logic           r_href;
    logic [7:0]     r_d;
    logic           r_frame_done;

    dvp_state_t     w_state_nxt;
    dvp_state_t     w_state_after;
    logic [H_W-1:0] w_h_nxt;
    logic [V_W-1:0] w_v_nxt;
    logic           w_pclk_nxt;
    logic           w_vsync_nxt;
    logic           w_href_nxt;
    logic [7:0]     w_d_nxt;
    logic           w_done_nxt;
    logic           w_last_line;
    logic           w_frame_end;
    logic           w_h_wrap;
    logic           w_href_now;
    logic [7:0]     w_pat_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_pclk       <= 1'b0;
            r_vsync      <= ~C_VSYNC_ACTIVE;
            r_href       <= ~C_HREF_ACTIVE;
            r_d          <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_h_cnt      <= w_h_nxt;
            r_v_cnt      <= w_v_nxt;
            r_pclk       <= w_pclk_nxt;
            r_vsync      <= w_vsync_nxt;
            r_href       <= w_href_nxt;
            r_d          <= w_d_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    // Per-state line budget and successor; zero-length states are skipped
    always_comb begin
        w_last_line   = 1'b0;
        w_state_after = ST_VSYNC;
        w_frame_end   = 1'b0;
        case (r_state)
            ST_VSYNC: begin
                w_last_line   = (r_v_cnt == C_VSYNC_LAST);
                w_state_after = (V_BACK != 0) ? ST_VBACK : ST_ACTIVE;
            end
            ST_VBACK: begin
                w_last_line   = (r_v_cnt == C_VBACK_LAST);
                w_state_after = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                w_last_line   = (r_v_cnt == C_ACTIVE_LAST);
                w_state_after = (V_FRONT != 0) ? ST_VFRONT : ST_VSYNC;
                w_frame_end   = (V_FRONT == 0);
            end
            ST_VFRONT: begin
                w_last_line   = (r_v_cnt == C_VFRONT_LAST);
                w_state_after = ST_VSYNC;
                w_frame_end   = 1'b1;
            end
            default: begin
                w_last_line   = 1'b0;
                w_state_after = ST_VSYNC;
            end
        endcase
    end

    assign w_h_wrap   = (r_h_cnt == C_H_LAST);
    assign w_href_now = (r_state == ST_ACTIVE) && (r_h_cnt < C_HREF_END);

    // Outputs registered on a tick describe the counter position before it
    // advances, so line byte 0 appears on the first tick of each line.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        w_pclk_nxt  = r_pclk;
        w_vsync_nxt = r_vsync;
        w_href_nxt  = r_href;
        w_d_nxt     = r_d;
        w_done_nxt  = 1'b0;

        if (r_pwdn_s) begin
            // Power-down wins immediately, whatever the tick phase
            w_state_nxt = ST_IDLE;
            w_h_nxt     = '0;
            w_v_nxt     = '0;
            w_pclk_nxt  = 1'b0;
            w_vsync_nxt = ~C_VSYNC_ACTIVE;
            w_href_nxt  = ~C_HREF_ACTIVE;
            w_d_nxt     = 8'h00;
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_VSYNC;
            w_h_nxt     = '0;
            w_v_nxt     = '0;
            w_pclk_nxt  = 1'b0;
        end else begin
            w_pclk_nxt = ~r_pclk;
            // pclk currently high -> this edge takes it low: a tick
            if (r_pclk) begin
                w_vsync_nxt = (r_state == ST_VSYNC) ? C_VSYNC_ACTIVE : ~C_VSYNC_ACTIVE;
                w_href_nxt  = w_href_now ? C_HREF_ACTIVE : ~C_HREF_ACTIVE;
                w_d_nxt     = w_pat_byte;
                if (w_h_wrap) begin
                    w_h_nxt = '0;
                    if (w_last_line) begin
                        w_v_nxt     = '0;
                        w_state_nxt = w_state_after;
                        w_done_nxt  = w_frame_end;
                    end else begin
                        w_v_nxt = r_v_cnt + V_W'(1);
                    end
                end else begin
                    w_h_nxt = r_h_cnt + H_W'(1);
                end
            end
        end
    end

    dvp_tx_pattern_gen #(
`ifdef DVP_TX_COLORBAR_EN
        .H_ACTIVE   (H_ACTIVE),
`endif
        .H_W        (H_W),
        .V_W        (V_W)
    ) u_pattern_gen (
        .i_h_cnt    (r_h_cnt),
        .i_line_idx (r_v_cnt),
        .i_href     (w_href_now),
        .o_byte     (w_pat_byte)
    );

    assign dvp_pclk_o   = r_pclk;
    assign dvp_vsync_o  = r_vsync;
    assign dvp_href_o   = r_href;
    assign dvp_d_o      = r_d;
    assign frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dvp_sensor_emulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dvp_sensor_emulator
// Description : Self-checking bench for dvp_sensor_emulator with an 8x4
//               frame (LINE_TICKS=20, 280-clk frame). Expected pixel bytes
//               are queued when a frame is released and popped at each PCLK
//               rise while HREF is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dvp_sensor_emulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwdn_i;
    logic       dvp_pclk_o;
    logic       dvp_vsync_o;
    logic       dvp_href_o;
    logic [7:0] dvp_d_o;
    logic       frame_done_o;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_d_neg = 8'h00;
    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    dvp_sensor_emulator #(
        .H_ACTIVE    (8),
        .V_ACTIVE    (4),
        .H_BLANK     (4),
        .VSYNC_LINES (1),
        .V_BACK      (1),
        .V_FRONT     (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwdn_i       (pwdn_i),
        .dvp_pclk_o   (dvp_pclk_o),
        .dvp_vsync_o  (dvp_vsync_o),
        .dvp_href_o   (dvp_href_o),
        .dvp_d_o      (dvp_d_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        last_d_neg = dvp_d_o;
        if (frame_done_o === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream of one frame (4 active lines x 16 bytes)
    task automatic push_frame();
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 16; b++) begin
`ifdef DVP_TX_COLORBAR_EN
                logic [15:0] c;
                c = bar_tab[b / 2];
                exp_q.push_back((b % 2 == 0) ? c[15:8] : c[7:0]);
`else
                exp_q.push_back(8'(b + l));
`endif
            end
        end
    endtask

    // Scoreboard / bus monitor at each PCLK rise
    always @(posedge dvp_pclk_o) begin
        #1;
        chk("d_stable_at_pclk_rise", 32'(dvp_d_o), 32'(last_d_neg));
        if (dvp_href_o === 1'b1) begin
            chk("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("sb_pixel_byte", 32'(dvp_d_o), 32'(e));
            end
        end else begin
            chk("d_zero_when_href_low", 32'(dvp_d_o), 32'd0);
        end
    end

    // Release power-down at a negedge and check the complete first frame
    task automatic release_and_check(output int done_cyc);
        bit ok;
        int entry_cyc;
        int vs_len;
        int hi;
        int lo;
        push_frame();
        pwdn_i = 1'b0;
        @(negedge clk); chk("pclk_low_sync1", 32'(dvp_pclk_o), 32'd0);
        @(negedge clk); chk("pclk_low_sync2", 32'(dvp_pclk_o), 32'd0);
        @(negedge clk); chk("pclk_low_entry", 32'(dvp_pclk_o), 32'd0);
        entry_cyc = cyc;
        @(negedge clk); chk("first_pclk_rise", 32'(dvp_pclk_o), 32'd1);
        @(negedge clk); chk("vsync_first_tick", 32'(dvp_vsync_o), 32'd1);
        vs_len = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dvp_vsync_o !== 1'b1) break;
            vs_len++;
        end
        chk("vsync_high_clk", 32'(vs_len), 32'd40);

        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dvp_href_o === 1'b1) begin ok = 1'b1; break; end
        end
        chk("href_first_seen", 32'(ok), 32'd1);
        for (int l = 0; l < 4; l++) begin
            hi = 1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (dvp_href_o !== 1'b1) break;
                hi++;
            end
            chk("href_high_clk", 32'(hi), 32'd32);
            if (l < 3) begin
                lo = 1;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (dvp_href_o === 1'b1) break;
                    lo++;
                end
                chk("href_low_clk", 32'(lo), 32'd8);
            end
        end

        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (frame_done_o === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("frame_done_seen", 32'(ok), 32'd1);
        done_cyc = cyc;
        chk("frame_done_latency", 32'(done_cyc - entry_cyc), 32'd280);
        @(negedge clk); chk("frame_done_width", 32'(frame_done_o), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit ok;
        bit quiet;
        int hrefs;
        int prev_done;
        int done_before;
        logic prev_h;

        rst_n  = 1'b0;
        pwdn_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pclk",  32'(dvp_pclk_o),   32'd0);
        chk("rst_vsync", 32'(dvp_vsync_o),  32'd0);
        chk("rst_href",  32'(dvp_href_o),   32'd0);
        chk("rst_d",     32'(dvp_d_o),      32'd0);
        chk("rst_done",  32'(frame_done_o), 32'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("pwdn_outputs_quiet",
                32'({dvp_pclk_o, dvp_vsync_o, dvp_href_o, frame_done_o, dvp_d_o}), 32'd0);
        end

        // Frame 1
        release_and_check(prev_done);

        // Frame 2: period and href pulse count
        push_frame();
        hrefs  = 0;
        prev_h = 1'b0;
        ok     = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dvp_href_o === 1'b1 && prev_h === 1'b0) hrefs++;
            prev_h = dvp_href_o;
            if (frame_done_o === 1'b1) begin ok = 1'b1; break; end
        end
        chk("frame2_done_seen", 32'(ok), 32'd1);
        chk("frame_period", 32'(cyc - prev_done), 32'd280);
        chk("href_pulses_per_frame", 32'(hrefs), 32'd4);
        chk("sb_drained_frame2", 32'(exp_q.size()), 32'd0);

        // Frame 3: power-down during active line 1
        push_frame();
        hrefs  = 0;
        prev_h = 1'b0;
        ok     = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dvp_href_o === 1'b1 && prev_h === 1'b0) hrefs++;
            prev_h = dvp_href_o;
            if (hrefs == 2) begin ok = 1'b1; break; end
        end
        chk("line1_href_seen", 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
        done_before = done_cnt;
        pwdn_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_href",  32'(dvp_href_o),  32'd0);
        chk("abort_pclk",  32'(dvp_pclk_o),  32'd0);
        chk("abort_vsync", 32'(dvp_vsync_o), 32'd0);
        chk("abort_d",     32'(dvp_d_o),     32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ({dvp_pclk_o, dvp_vsync_o, dvp_href_o, frame_done_o, dvp_d_o} !== 12'd0)
                quiet = 1'b0;
        end
        chk("abort_hold_quiet", 32'(quiet), 32'd1);
        chk("no_done_on_abort", 32'(done_cnt), 32'(done_before));
        exp_q.delete();

        // Frame 4: clean restart after the aborted frame
        release_and_check(prev_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
